// File: rtl/costas_pkg.sv
// Shared widths, FSM state type and saturating arithmetic helpers for the
// Costas carrier-recovery loop controller.
package costas_pkg;

    localparam int unsigned IN_WIDTH = 16;
    localparam int unsigned ACC_LOG2 = 6;
    localparam int unsigned ACC_W    = IN_WIDTH + ACC_LOG2;
    localparam int unsigned PINC_W   = 32;
    localparam int unsigned ERR_W    = IN_WIDTH;

    localparam logic [PINC_W-1:0] PINC_CENTER_DEF = 32'h0CCC_CCCD;
    localparam int unsigned       KP_SHL_DEF      = 8;
    localparam int unsigned       KI_SHL_DEF      = 2;
    localparam logic [PINC_W-1:0] INT_LIM_DEF     = 32'h0100_0000;
    localparam int unsigned       LOCK_WIN_DEF    = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INTEG = 3'd1,
        DUMP  = 3'd2,
        FILT  = 3'd3,
        OUT   = 3'd4
    } state_t;

    // Two's-complement negate that maps the most negative value to the most positive.
    function automatic logic signed [IN_WIDTH-1:0] neg_sat(input logic signed [IN_WIDTH-1:0] x);
        if (x == {1'b1, {(IN_WIDTH-1){1'b0}}}) begin
            return {1'b0, {(IN_WIDTH-1){1'b1}}};
        end
        return -x;
    endfunction

    function automatic logic [IN_WIDTH-1:0] abs_sat(input logic signed [IN_WIDTH-1:0] x);
        return x[IN_WIDTH-1] ? neg_sat(x) : x;
    endfunction

    // Clamp a widened signed value to the symmetric range [-lim, +lim].
    function automatic logic signed [PINC_W:0] sat_sym(input logic signed [PINC_W:0] x,
                                                       input logic [PINC_W-1:0]   lim);
        logic signed [PINC_W:0] hi;
        logic signed [PINC_W:0] lo;
        hi = $signed({1'b0, lim});
        lo = -hi;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/costas_loop_filter.sv
// PI loop filter: saturating integrator plus proportional path, producing the
// DDS phase increment. Both integrator and increment update only when en is high.
module costas_loop_filter
    import costas_pkg::*;
#(
    parameter logic [PINC_W-1:0] PINC_CENTER = PINC_CENTER_DEF,
    parameter int unsigned       KP_SHL      = KP_SHL_DEF,
    parameter int unsigned       KI_SHL      = KI_SHL_DEF,
    parameter logic [PINC_W-1:0] INT_LIM     = INT_LIM_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [ERR_W-1:0] err,
    output logic [PINC_W-1:0]       integ,
    output logic [PINC_W-1:0]       pinc
);

    logic signed [PINC_W-1:0] err_ext;
    logic signed [PINC_W-1:0] ki_term;
    logic signed [PINC_W-1:0] kp_term;
    logic signed [PINC_W:0]   integ_sum;
    logic signed [PINC_W:0]   integ_sat;
    logic [PINC_W-1:0]        integ_next;
    logic [PINC_W-1:0]        pinc_next;

    always_comb begin
        err_ext    = {{(PINC_W-ERR_W){err[ERR_W-1]}}, err};
        ki_term    = err_ext <<< KI_SHL;
        kp_term    = err_ext <<< KP_SHL;
        // One guard bit keeps the sum exact before clamping.
        integ_sum  = {integ[PINC_W-1], integ} + {ki_term[PINC_W-1], ki_term};
        integ_sat  = sat_sym(integ_sum, INT_LIM);
        integ_next = integ_sat[PINC_W-1:0];
        pinc_next  = PINC_CENTER + kp_term + integ_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            integ <= '0;
            pinc  <= PINC_CENTER;
        end else if (en) begin
            integ <= integ_next;
            pinc  <= pinc_next;
        end
    end

endmodule

// File: rtl/costas_loop_ctrl.sv
// Costas loop controller: integrate-and-dump of I/Q mixer products, phase error,
// PI filter and lock detection, emitting one DDS phase-increment update per window.
module costas_loop_ctrl
    import costas_pkg::*;
#(
    parameter logic [PINC_W-1:0] PINC_CENTER = PINC_CENTER_DEF,
    parameter int unsigned       KP_SHL      = KP_SHL_DEF,
    parameter int unsigned       KI_SHL      = KI_SHL_DEF,
    parameter logic [PINC_W-1:0] INT_LIM     = INT_LIM_DEF,
    parameter int unsigned       LOCK_WIN    = LOCK_WIN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [IN_WIDTH-1:0] S_AXIS_I_mult_tdata,
    input  logic                S_AXIS_I_mult_tvalid,
    input  logic [IN_WIDTH-1:0] S_AXIS_Q_mult_tdata,
    input  logic                S_AXIS_Q_mult_tvalid,
    output logic [PINC_W-1:0]   M_AXIS_PINC_tdata,
    output logic                M_AXIS_PINC_tvalid,
    output logic                locked,
    output logic [ERR_W-1:0]    debug_err,
    output logic [PINC_W-1:0]   debug_integ
);

    localparam int unsigned           LOCK_CNT_W = $clog2(LOCK_WIN + 1);
    localparam logic [LOCK_CNT_W-1:0] LOCK_MAX   = LOCK_CNT_W'(LOCK_WIN);

    state_t state;
    state_t state_next;

    logic accept_c;
    logic clear_c;
    logic dump_c;
    logic filt_c;
    logic out_c;

    logic signed [ACC_W-1:0]    iacc;
    logic signed [ACC_W-1:0]    qacc;
    logic [ACC_LOG2-1:0]        cnt;
    logic signed [IN_WIDTH-1:0] imean;
    logic signed [IN_WIDTH-1:0] qmean;
    logic signed [IN_WIDTH-1:0] imean_c;
    logic signed [IN_WIDTH-1:0] qmean_c;
    logic signed [ERR_W-1:0]    err_c;
    logic                       good_c;
    logic [LOCK_CNT_W-1:0]      lock_cnt;
    logic [LOCK_CNT_W-1:0]      lock_cnt_next_c;
    logic [PINC_W-1:0]          pinc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dropping enable aborts the window from any state; nothing past it is issued.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        clear_c    = 1'b0;
        dump_c     = 1'b0;
        filt_c     = 1'b0;
        out_c      = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            clear_c    = 1'b1;
        end else begin
            unique case (state)
                IDLE:  state_next = INTEG;
                INTEG: begin
                    accept_c = S_AXIS_I_mult_tvalid & S_AXIS_Q_mult_tvalid;
                    if (accept_c && (cnt == '1)) begin
                        state_next = DUMP;
                    end
                end
                DUMP: begin
                    dump_c     = 1'b1;
                    state_next = FILT;
                end
                FILT: begin
                    filt_c     = 1'b1;
                    state_next = OUT;
                end
                OUT: begin
                    out_c      = 1'b1;
                    clear_c    = 1'b1;
                    state_next = INTEG;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_c) begin
            iacc <= '0;
            qacc <= '0;
            cnt  <= '0;
        end else if (accept_c) begin
            iacc <= iacc + {{ACC_LOG2{S_AXIS_I_mult_tdata[IN_WIDTH-1]}}, S_AXIS_I_mult_tdata};
            qacc <= qacc + {{ACC_LOG2{S_AXIS_Q_mult_tdata[IN_WIDTH-1]}}, S_AXIS_Q_mult_tdata};
            cnt  <= cnt + ACC_LOG2'(1);
        end
    end

    // Window means, phase error and lock quality for the closing window.
    always_comb begin
        imean_c = iacc[ACC_LOG2 +: IN_WIDTH];
        qmean_c = qacc[ACC_LOG2 +: IN_WIDTH];
        err_c   = imean_c[IN_WIDTH-1] ? neg_sat(qmean_c) : qmean_c;
        good_c  = {1'b0, abs_sat(imean)} > {abs_sat(qmean), 1'b0};
        if (!good_c) begin
            lock_cnt_next_c = '0;
        end else if (lock_cnt == LOCK_MAX) begin
            lock_cnt_next_c = lock_cnt;
        end else begin
            lock_cnt_next_c = lock_cnt + LOCK_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imean     <= '0;
            qmean     <= '0;
            debug_err <= '0;
        end else if (dump_c) begin
            imean     <= imean_c;
            qmean     <= qmean_c;
            debug_err <= err_c;
        end
    end

    costas_loop_filter #(
        .PINC_CENTER (PINC_CENTER),
        .KP_SHL      (KP_SHL),
        .KI_SHL      (KI_SHL),
        .INT_LIM     (INT_LIM)
    ) u_filter (
        .clk   (clk),
        .rst   (rst),
        .en    (filt_c),
        .err   (debug_err),
        .integ (debug_integ),
        .pinc  (pinc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            M_AXIS_PINC_tdata  <= PINC_CENTER;
            M_AXIS_PINC_tvalid <= 1'b0;
            locked             <= 1'b0;
            lock_cnt           <= '0;
        end else begin
            M_AXIS_PINC_tvalid <= out_c;
            if (out_c) begin
                M_AXIS_PINC_tdata <= pinc;
                lock_cnt          <= lock_cnt_next_c;
                locked            <= (lock_cnt_next_c == LOCK_MAX);
            end
        end
    end

endmodule

// File: tb/tb_costas_loop_ctrl.sv
// Directed bench for costas_loop_ctrl: a behavioural loop model pushes each
// window's expected DDS update into a queue, popped when the DUT strobes tvalid.
module tb_costas_loop_ctrl;

    localparam logic [31:0] CENTER  = 32'h0CCC_CCCD;
    localparam longint      LIM     = 64'sd16777216;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] i_data;
    logic        i_valid;
    logic [15:0] q_data;
    logic        q_valid;
    logic [31:0] pinc_tdata;
    logic        pinc_tvalid;
    logic        locked;
    logic [15:0] debug_err;
    logic [31:0] debug_integ;

    typedef struct {
        logic [31:0] pinc;
        logic [31:0] integ;
        logic [15:0] err;
        logic        lock;
        int          due;
    } exp_t;

    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc   = 0;

    int     isum, qsum;
    longint m_integ;
    int     m_cnt;
    logic   m_locked;
    logic [31:0] m_pinc;

    costas_loop_ctrl dut (
        .clk                  (clk),
        .rst                  (rst),
        .enable               (enable),
        .S_AXIS_I_mult_tdata  (i_data),
        .S_AXIS_I_mult_tvalid (i_valid),
        .S_AXIS_Q_mult_tdata  (q_data),
        .S_AXIS_Q_mult_tvalid (q_valid),
        .M_AXIS_PINC_tdata    (pinc_tdata),
        .M_AXIS_PINC_tvalid   (pinc_tvalid),
        .locked               (locked),
        .debug_err            (debug_err),
        .debug_integ          (debug_integ)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int neg_sat16(input int x);
        return (x == -32768) ? 32767 : -x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int i, input int q, input logic vi, input logic vq);
        i_data  = 16'(i);
        q_data  = 16'(q);
        i_valid = vi;
        q_valid = vq;
    endtask

    task automatic model_reset();
        isum     = 0;
        qsum     = 0;
        m_integ  = 0;
        m_cnt    = 0;
        m_locked = 1'b0;
        m_pinc   = CENTER;
    endtask

    // Loop model for one closed window; called right after the edge taking sample N.
    task automatic close_window();
        int     im, qm, er, ai, aq;
        longint ig;
        exp_t   e;
        im = isum >>> 6;
        qm = qsum >>> 6;
        er = (im < 0) ? neg_sat16(qm) : qm;
        ig = m_integ + longint'(er) * 4;
        if (ig > LIM) ig = LIM;
        if (ig < -LIM) ig = -LIM;
        m_integ = ig;
        m_pinc  = 32'(longint'(CENTER) + longint'(er) * 256 + ig);
        ai = (im < 0) ? neg_sat16(im) : im;
        aq = (qm < 0) ? neg_sat16(qm) : qm;
        if (ai > 2 * aq) begin
            if (m_cnt < 16) m_cnt++;
            m_locked = (m_cnt == 16);
        end else begin
            m_cnt    = 0;
            m_locked = 1'b0;
        end
        e.pinc  = m_pinc;
        e.integ = 32'(m_integ);
        e.err   = 16'(er);
        e.lock  = m_locked;
        e.due   = cyc + 3;
        sb.push_back(e);
        isum = 0;
        qsum = 0;
    endtask

    // 64 joint-valid samples; optional idle gaps, I-only and Q-only junk cycles.
    task automatic run_window(input int ib, input int qb, input int jit, input bit gaps);
        int i, q;
        for (int k = 0; k < 64; k++) begin
            if (gaps) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_in(0, 0, 1'b0, 1'b0);
                    step();
                end
                if (k < 10) begin
                    set_in(20000, 0, 1'b1, 1'b0);
                    step();
                end
                if (k % 7 == 3) begin
                    set_in(0, -20000, 1'b0, 1'b1);
                    step();
                end
            end
            i = ib + ((jit > 0) ? int'($urandom_range(0, 2 * jit)) - jit : 0);
            q = qb + ((jit > 0) ? int'($urandom_range(0, 2 * jit)) - jit : 0);
            set_in(i, q, 1'b1, 1'b1);
            step();
            isum += i;
            qsum += q;
        end
        close_window();
        set_in(0, 0, 1'b0, 1'b0);
        repeat (3) step();
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && sb.size() != 0; t++) step();
        chk("pending_updates", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = 1'b0;
        set_in(0, 0, 1'b0, 1'b0);
        repeat (2) step();
        model_reset();
        chk("rst_tdata", pinc_tdata, CENTER);
        chk("rst_tvalid", 32'(pinc_tvalid), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_integ", debug_integ, 32'd0);
        chk("rst_err", 32'(debug_err), 32'd0);
        rst    = 1'b0;
        enable = 1'b1;
        step();
    endtask

    // Every tvalid strobe must match the oldest outstanding window, on time.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && pinc_tvalid) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_tvalid: observed strobe at cycle %0d expected none", cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("latency", 32'(cyc), 32'(e.due));
                chk("pinc", pinc_tdata, e.pinc);
                chk("integ", debug_integ, e.integ);
                chk("err", 32'(debug_err), 32'(e.err));
                chk("locked", 32'(locked), 32'(e.lock));
            end
        end
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        set_in(0, 0, 1'b0, 1'b0);

        // Reset, then one constant window: err=100, integ=400, pinc=center+26000.
        do_reset();
        run_window(1000, 100, 0, 1'b0);
        drain();
        chk("const_pinc", pinc_tdata, CENTER + 32'd26000);
        chk("const_integ", debug_integ, 32'd400);

        // Sign flip from reset: err=-100, integ=-400.
        do_reset();
        run_window(-1000, 100, 0, 1'b0);
        drain();
        chk("flip_pinc", pinc_tdata, CENTER - 32'd26000);
        chk("flip_integ", debug_integ, 32'hFFFF_FE70);

        // Partial window aborted by enable: no strobe, loop state holds.
        run_window(1500, -200, 0, 1'b0);
        drain();
        for (int k = 0; k < 40; k++) begin
            set_in(5000, 5000, 1'b1, 1'b1);
            step();
        end
        enable = 1'b0;
        set_in(0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("abort_tvalid", 32'(pinc_tvalid), 32'd0);
        end
        chk("abort_integ_hold", debug_integ, 32'(m_integ));
        chk("abort_pinc_hold", pinc_tdata, m_pinc);
        chk("abort_lock_hold", 32'(locked), 32'(m_locked));
        isum   = 0;
        qsum   = 0;
        enable = 1'b1;
        step();

        // Fresh 64 after restart, with valid gaps and mismatched valids.
        run_window(2000, -300, 50, 1'b1);
        run_window(-1200, 400, 80, 1'b1);
        drain();

        // Lock: 16 good windows lock, one poor window drops it.
        do_reset();
        for (int w = 0; w < 16; w++) run_window(1000, 100, 0, 1'b0);
        drain();
        chk("lock_set", 32'(locked), 32'd1);
        run_window(1000, 600, 0, 1'b0);
        drain();
        chk("lock_drop", 32'(locked), 32'd0);

        // Integrator saturation at +INT_LIM.
        for (int w = 0; w < 160; w++) run_window(30000, 30000, 0, 1'b0);
        drain();
        chk("sat_integ", debug_integ, 32'h0100_0000);
        chk("sat_pinc", pinc_tdata, CENTER + 32'd7680000 + 32'h0100_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
